// File: rtl/timer_seq_ctrl.sv
// APB master sequencer that programs the 8-bit timer, services its overflow or
// underflow flag for a commanded number of periods, then stops it and reports.
module timer_seq_ctrl #(
    parameter logic [7:0]  ADDR_TDR = 8'h00,
    parameter logic [7:0]  ADDR_TCR = 8'h01,
    parameter logic [7:0]  ADDR_TSR = 8'h02,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] reload_val,
    input  logic       mode_updw,
    input  logic [1:0] cks,
    input  logic [7:0] periods,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] event_cnt,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK_TSR,
        S_CLR0,
        S_WR_TDR,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_POLL,
        S_ACK,
        S_STOP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } phase_t;

    state_t           state;
    state_t           state_nx;
    state_t           after_xfer;
    phase_t           phase;
    phase_t           phase_nx;
    logic [GAP_W-1:0] gap_cnt;

    logic [7:0] reload_r;
    logic       mode_r;
    logic [1:0] cks_r;
    logic [7:0] periods_r;
    logic       abort_pend;

    logic       bus_state;
    logic       xfer_done;
    logic       abort_any;
    logic       accept;
    logic [7:0] flag_mask;
    logic       flag_hit;
    logic       flag_bad;
    logic [7:0] tcr_base;
    logic [7:0] cnt_inc;

    assign bus_state = (state == S_CHK_TSR) || (state == S_CLR0) || (state == S_WR_TDR) ||
                       (state == S_LOAD) || (state == S_RUN) || (state == S_POLL) ||
                       (state == S_ACK) || (state == S_STOP);
    assign xfer_done = bus_state && (phase == PH_ACCESS) && pready;
    assign abort_any = abort || abort_pend;
    assign accept    = (state == S_IDLE) && start;
    assign flag_mask = mode_r ? 8'h02 : 8'h01;
    assign flag_hit  = |(prdata & flag_mask);
    assign flag_bad  = |(prdata & ~flag_mask);
    assign tcr_base  = {2'b00, mode_r, 3'b000, cks_r};
    assign cnt_inc   = (event_cnt == 8'hFF) ? 8'hFF : event_cnt + 8'h01;

    // State, bus phase and gap counter; reset drops any transfer in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= S_IDLE;
            phase   <= PH_IDLE;
            gap_cnt <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            if ((state_nx == S_GAP) && (state != S_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == S_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Destination once the current transfer completes; errors outrank abort.
    always_comb begin
        after_xfer = S_STOP;
        if (state == S_STOP) begin
            after_xfer = S_DONE;
        end else if (pslverr || ((state == S_POLL) && flag_bad) || abort_any) begin
            after_xfer = S_STOP;
        end else begin
            case (state)
                S_CHK_TSR: after_xfer = (prdata != 8'h00) ? S_CLR0 : S_WR_TDR;
                S_CLR0:    after_xfer = S_WR_TDR;
                S_WR_TDR:  after_xfer = S_LOAD;
                S_LOAD:    after_xfer = S_RUN;
                S_RUN:     after_xfer = S_GAP;
                S_POLL:    after_xfer = flag_hit ? S_ACK : S_GAP;
                S_ACK:     after_xfer = (cnt_inc == periods_r) ? S_STOP : S_GAP;
                default:   after_xfer = S_STOP;
            endcase
        end
    end

    // Next state; a poll entered from GAP skips its idle phase since GAP already idled the bus.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (periods == 8'h00) ? S_DONE : S_CHK_TSR;
                    phase_nx = PH_IDLE;
                end
            end
            S_GAP: begin
                if (abort_any) begin
                    state_nx = S_STOP;
                    phase_nx = PH_SETUP;
                end else if (gap_cnt == '0) begin
                    state_nx = S_POLL;
                    phase_nx = PH_SETUP;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                phase_nx = PH_IDLE;
            end
            default: begin
                case (phase)
                    PH_IDLE: begin
                        if (abort_any && (state != S_STOP)) begin
                            state_nx = S_STOP;
                        end
                        phase_nx = PH_SETUP;
                    end
                    PH_SETUP: phase_nx = PH_ACCESS;
                    default: begin
                        if (pready) begin
                            state_nx = after_xfer;
                            phase_nx = PH_IDLE;
                        end
                    end
                endcase
            end
        endcase
    end

    // Run parameters, sticky error, event counter and latched abort request.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            reload_r   <= 8'h00;
            mode_r     <= 1'b0;
            cks_r      <= 2'b00;
            periods_r  <= 8'h00;
            err        <= 1'b0;
            event_cnt  <= 8'h00;
            abort_pend <= 1'b0;
        end else if (accept) begin
            reload_r   <= reload_val;
            mode_r     <= mode_updw;
            cks_r      <= cks;
            periods_r  <= periods;
            err        <= 1'b0;
            event_cnt  <= 8'h00;
            abort_pend <= 1'b0;
        end else begin
            if (xfer_done && (pslverr || ((state == S_POLL) && flag_bad))) begin
                err <= 1'b1;
            end
            if (xfer_done && (state == S_ACK)) begin
                event_cnt <= cnt_inc;
            end
            if (abort && (state != S_IDLE) && (state != S_DONE) && (state != S_STOP)) begin
                abort_pend <= 1'b1;
            end
        end
    end

    // Bus and status outputs decoded from state and phase; address and data hold for the whole state.
    always_comb begin
        psel    = bus_state && (phase != PH_IDLE);
        penable = bus_state && (phase == PH_ACCESS);
        busy    = (state != S_IDLE) && (state != S_DONE);
        done    = (state == S_DONE);
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        case (state)
            S_CHK_TSR: begin
                paddr = ADDR_TSR;
            end
            S_CLR0: begin
                pwrite = 1'b1;
                paddr  = ADDR_TSR;
            end
            S_WR_TDR: begin
                pwrite = 1'b1;
                paddr  = ADDR_TDR;
                pwdata = reload_r;
            end
            S_LOAD: begin
                pwrite = 1'b1;
                paddr  = ADDR_TCR;
                pwdata = tcr_base | 8'h80;
            end
            S_RUN: begin
                pwrite = 1'b1;
                paddr  = ADDR_TCR;
                pwdata = tcr_base | 8'h10;
            end
            S_POLL: begin
                paddr = ADDR_TSR;
            end
            S_ACK: begin
                pwrite = 1'b1;
                paddr  = ADDR_TSR;
            end
            S_STOP: begin
                pwrite = 1'b1;
                paddr  = ADDR_TCR;
            end
            default: begin
                pwrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: a scripted APB slave, a bus/done scoreboard monitor,
// and directed runs with hand-computed bus sequences and results.
module tb_timer_seq_ctrl;

    localparam logic [7:0] TDR = 8'h00;
    localparam logic [7:0] TCR = 8'h01;
    localparam logic [7:0] TSR = 8'h02;

    typedef struct packed {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } bus_t;

    typedef struct packed {
        logic       e;
        logic [7:0] c;
    } done_t;

    logic       pclk;
    logic       presetn;
    logic       start;
    logic       abort;
    logic [7:0] reload_val;
    logic       mode_updw;
    logic [1:0] cks;
    logic [7:0] periods;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] event_cnt;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int vectors    = 0;
    int miscompares = 0;

    bus_t  exp_bus[$];
    done_t exp_done[$];
    logic [7:0] tsr_q[$];

    int         wait_states = 0;
    int         wcnt        = 0;
    logic       err_en      = 1'b0;
    logic [7:0] err_addr    = 8'h00;
    logic [7:0] err_data    = 8'h00;
    bus_t       cap;

    timer_seq_ctrl dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .start      (start),
        .abort      (abort),
        .reload_val (reload_val),
        .mode_updw  (mode_updw),
        .cks        (cks),
        .periods    (periods),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .event_cnt  (event_cnt),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
        exp_bus.push_back('{w: 1'b1, a: a, d: d});
    endtask

    task automatic exp_r(input logic [7:0] rsp);
        exp_bus.push_back('{w: 1'b0, a: TSR, d: 8'h00});
        tsr_q.push_back(rsp);
    endtask

    // Slave: responds just after each edge, scripted TSR read data, optional error on one write.
    always @(posedge pclk) begin
        #1;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 8'h00;
        if (psel && penable) begin
            if (wcnt >= wait_states) begin
                wcnt   = 0;
                pready = 1'b1;
                if (!pwrite && (paddr == TSR) && (tsr_q.size() != 0)) begin
                    prdata = tsr_q.pop_front();
                end
                if (err_en && pwrite && (paddr == err_addr) && (pwdata == err_data)) begin
                    pslverr = 1'b1;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Monitor: checks held bus fields, completed transfers and done reports against the queues.
    always @(negedge pclk) begin
        bus_t  got;
        bus_t  want;
        done_t dwant;
        if (presetn) begin
            if (psel && !penable) begin
                cap = '{w: pwrite, a: paddr, d: pwdata};
            end
            if (psel && penable) begin
                got = '{w: pwrite, a: paddr, d: pwdata};
                check_output("bus_hold", 32'(got), 32'(cap));
                if (pready) begin
                    if (exp_bus.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_xfer: got w=%0b a=%0h d=%0h, expected none",
                                 got.w, got.a, got.d);
                    end else begin
                        want = exp_bus.pop_front();
                        if (!want.w) begin
                            got.d = 8'h00;
                        end
                        check_output("bus_xfer", 32'(got), 32'(want));
                    end
                end
            end
            if (done) begin
                check_output("done_busy", 32'(busy), 32'(0));
                if (exp_done.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_done: got err=%0b cnt=%0h, expected none", err, event_cnt);
                end else begin
                    dwant = exp_done.pop_front();
                    check_output("done_err", 32'(err), 32'(dwant.e));
                    check_output("done_cnt", 32'(event_cnt), 32'(dwant.c));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] rv, input logic md, input logic [1:0] ck,
                                  input logic [7:0] per, input int extra_start, input int abort_cnt);
        bit got_done = 1'b0;
        bit aborted  = 1'b0;
        reload_val = rv;
        mode_updw  = md;
        cks        = ck;
        periods    = per;
        start      = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        check_output("start_busy", 32'(busy), 32'(per != 8'h00));
        check_output("start_done", 32'(done), 32'(per == 8'h00));
        check_output("start_err", 32'(err), 32'(0));
        check_output("start_cnt", 32'(event_cnt), 32'(0));
        check_output("start_psel", 32'(psel), 32'(0));
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            start = (i == extra_start);
            abort = 1'b0;
            if ((abort_cnt >= 0) && !aborted && busy && (event_cnt == 8'(abort_cnt))) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            @(negedge pclk);
        end
        start = 1'b0;
        abort = 1'b0;
        check_output("done_seen", 32'(got_done), 32'(1));
        repeat (2) @(negedge pclk);
        check_output("bus_left", 32'(exp_bus.size()), 32'(0));
        check_output("done_left", 32'(exp_done.size()), 32'(0));
        exp_bus.delete();
        exp_done.delete();
        tsr_q.delete();
    endtask

    initial begin
        presetn    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        reload_val = 8'h00;
        mode_updw  = 1'b0;
        cks        = 2'b00;
        periods    = 8'h00;
        prdata     = 8'h00;
        pready     = 1'b0;
        pslverr    = 1'b0;
        repeat (3) @(negedge pclk);
        check_output("rst_busy", 32'(busy), 32'(0));
        check_output("rst_done", 32'(done), 32'(0));
        check_output("rst_err", 32'(err), 32'(0));
        check_output("rst_cnt", 32'(event_cnt), 32'(0));
        check_output("rst_bus", 32'({psel, penable, pwrite, paddr, pwdata}), 32'(0));
        presetn = 1'b1;
        @(negedge pclk);

        $display("[TB] up mode, one period, stray start while busy");
        exp_r(8'h00); exp_w(TDR, 8'h80); exp_w(TCR, 8'h80); exp_w(TCR, 8'h10);
        exp_r(8'h00); exp_r(8'h00); exp_r(8'h01); exp_w(TSR, 8'h00); exp_w(TCR, 8'h00);
        exp_done.push_back('{e: 1'b0, c: 8'd1});
        apply_stimulus(8'h80, 1'b0, 2'd0, 8'd1, 10, -1);

        $display("[TB] down mode, flag preset, three periods");
        exp_r(8'h01); exp_w(TSR, 8'h00); exp_w(TDR, 8'h20); exp_w(TCR, 8'hA1); exp_w(TCR, 8'h31);
        exp_r(8'h02); exp_w(TSR, 8'h00); exp_r(8'h00); exp_r(8'h02); exp_w(TSR, 8'h00);
        exp_r(8'h02); exp_w(TSR, 8'h00); exp_w(TCR, 8'h00);
        exp_done.push_back('{e: 1'b0, c: 8'd3});
        apply_stimulus(8'h20, 1'b1, 2'd1, 8'd3, -1, -1);

        $display("[TB] down mode, wrong flag raises error");
        exp_r(8'h00); exp_w(TDR, 8'h20); exp_w(TCR, 8'hA1); exp_w(TCR, 8'h31);
        exp_r(8'h02); exp_w(TSR, 8'h00); exp_r(8'h01); exp_w(TCR, 8'h00);
        exp_done.push_back('{e: 1'b1, c: 8'd1});
        apply_stimulus(8'h20, 1'b1, 2'd1, 8'd3, -1, -1);

        $display("[TB] zero periods");
        exp_done.push_back('{e: 1'b0, c: 8'd0});
        apply_stimulus(8'h55, 1'b0, 2'd0, 8'd0, -1, -1);

        $display("[TB] up mode with three wait states");
        wait_states = 3;
        exp_r(8'h00); exp_w(TDR, 8'h80); exp_w(TCR, 8'h80); exp_w(TCR, 8'h10);
        exp_r(8'h00); exp_r(8'h00); exp_r(8'h01); exp_w(TSR, 8'h00); exp_w(TCR, 8'h00);
        exp_done.push_back('{e: 1'b0, c: 8'd1});
        apply_stimulus(8'h80, 1'b0, 2'd0, 8'd1, -1, -1);
        wait_states = 0;

        $display("[TB] slave error on run write");
        err_en   = 1'b1;
        err_addr = TCR;
        err_data = 8'h12;
        exp_r(8'h00); exp_w(TDR, 8'h40); exp_w(TCR, 8'h82); exp_w(TCR, 8'h12); exp_w(TCR, 8'h00);
        exp_done.push_back('{e: 1'b1, c: 8'd0});
        apply_stimulus(8'h40, 1'b0, 2'd2, 8'd2, -1, -1);
        err_en = 1'b0;

        $display("[TB] abort during gap after two events");
        exp_r(8'h00); exp_w(TDR, 8'h10); exp_w(TCR, 8'h83); exp_w(TCR, 8'h13);
        exp_r(8'h00); exp_r(8'h01); exp_w(TSR, 8'h00); exp_r(8'h01); exp_w(TSR, 8'h00);
        exp_w(TCR, 8'h00);
        exp_done.push_back('{e: 1'b0, c: 8'd2});
        apply_stimulus(8'h10, 1'b0, 2'd3, 8'd5, -1, 2);
        check_output("cnt_hold", 32'(event_cnt), 32'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
